golden_nonce_tx_framer: RTL and testbench

- Sits directly downstream of the miner core, between it and the UART transmit path.
- Captures every golden nonce the miner reports and queues it in a small FIFO.
- Each queued nonce leaves as a 5-byte frame (SOF byte + 4 nonce bytes, MSB first) over a valid/ready byte interface that feeds the UART transmitter.
- Nonces found in a burst are never lost silently: the block either queues them or counts the drop.

---
 rtl/golden_nonce_pkg.sv | 17 +
 rtl/nonce_sync_fifo.sv | 63 ++++++
 rtl/golden_nonce_tx_framer.sv | 97 +++++++++
 tb/tb_golden_nonce_tx_framer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/golden_nonce_pkg.sv
// Shared types and constants for the golden-nonce transmit framer.
// Holds the framer state enum, default start-of-frame byte and frame length.
package golden_nonce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        B3,
        B2,
        B1,
        B0
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN   = 5;

endpackage

// File: rtl/nonce_sync_fifo.sv
// Single-clock nonce FIFO; full/empty come from the occupancy count.
// Ports: clk, reset, push, pop, clear, din -> dout (head, combinational), count, full, empty.
module nonce_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_idx;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push coinciding with clear lands in slot 0 of the emptied queue.
    assign wr_idx = clear ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            if (push) begin
                wr_ptr <= AW'(1);
                count  <= CW'(1);
            end else begin
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/golden_nonce_tx_framer.sv
// Queues golden nonces and emits each as SOF + 4 bytes (MSB first) on a valid/ready byte stream.
// Ports: hash_clk, reset, new_golden_ticket, golden_nonce, flush, tx_ready -> tx_valid, tx_data, fifo_count, overflow, drop_count, busy.
module golden_nonce_tx_framer
    import golden_nonce_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
    parameter int         CNT_W    = 8
) (
    input  logic                   hash_clk,
    input  logic                   reset,
    input  logic                   new_golden_ticket,
    input  logic [31:0]            golden_nonce,
    input  logic                   flush,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   busy
);

    state_t      state;
    logic [31:0] shreg;
    logic [31:0] head;
    logic        hs;
    logic        pop;
    logic        push_ok;
    logic        full;
    logic        empty;

    assign hs   = tx_valid && tx_ready;
    assign busy = (state != IDLE);

    // Pop when idle, or chain straight into the next frame as B0 completes.
    assign pop = !empty && ((state == IDLE) || (state == B0 && hs));

    // Flush empties the queue, so a push alongside it always fits.
    assign push_ok = new_golden_ticket && (flush || !full || pop);

    nonce_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (hash_clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .clear (flush),
        .din   (golden_nonce),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            shreg    <= '0;
        end else if (pop) begin
            state    <= SOF;
            tx_valid <= 1'b1;
            tx_data  <= SOF_BYTE;
            shreg    <= head;
        end else if (hs) begin
            // Next byte always comes from the top of the shift register.
            tx_data <= shreg[31:24];
            shreg   <= {shreg[23:0], 8'h00};
            case (state)
                SOF: state <= B3;
                B3:  state <= B2;
                B2:  state <= B1;
                B1:  state <= B0;
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset || flush) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (new_golden_ticket && !push_ok) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_golden_nonce_tx_framer.sv
// Scoreboard bench for golden_nonce_tx_framer: directed scenarios then random traffic.
// A queue-level reference model predicts bytes and status; a negedge monitor compares.
module tb_golden_nonce_tx_framer;

    localparam int DEPTH = 4;

    logic        hash_clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_golden_ticket = 1'b0;
    logic [31:0] golden_nonce = '0;
    logic        flush = 1'b0;
    logic        tx_ready = 1'b0;

    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        busy;

    logic        tx_valid2;
    logic [7:0]  tx_data2;
    logic [2:0]  fifo_count2;
    logic        overflow2;
    logic [1:0]  drop_count2;
    logic        busy2;

    always #5 hash_clk = ~hash_clk;

    golden_nonce_tx_framer #(.DEPTH(DEPTH), .SOF_BYTE(8'hA5), .CNT_W(8)) dut (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .new_golden_ticket (new_golden_ticket),
        .golden_nonce      (golden_nonce),
        .flush             (flush),
        .tx_ready          (tx_ready),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .drop_count        (drop_count),
        .busy              (busy)
    );

    golden_nonce_tx_framer #(.DEPTH(DEPTH), .SOF_BYTE(8'hA5), .CNT_W(2)) dut2 (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .new_golden_ticket (new_golden_ticket),
        .golden_nonce      (golden_nonce),
        .flush             (flush),
        .tx_ready          (tx_ready),
        .tx_valid          (tx_valid2),
        .tx_data           (tx_data2),
        .fifo_count        (fifo_count2),
        .overflow          (overflow2),
        .drop_count        (drop_count2),
        .busy              (busy2)
    );

    // Reference model: nonce queue, bytes of the frame still to send,
    // and the expected byte stream consumed by the monitor.
    logic [31:0] mq [$];
    logic [7:0]  fq [$];
    logic [7:0]  exp_q [$];
    int          m_drop;
    int          m_drop2;
    bit          m_ovf;
    bit          mon_en = 1'b0;

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    task automatic model_step(input logic t, input logic [31:0] n, input logic f,
                              input logic r, input logic rs);
        bit pop;
        bit acc;
        logic [31:0] nn;
        if (rs) begin
            mq.delete();
            fq.delete();
            exp_q.delete();
            m_drop  = 0;
            m_drop2 = 0;
            m_ovf   = 1'b0;
            return;
        end
        if (fq.size() > 0 && r) void'(fq.pop_front());
        pop = (fq.size() == 0) && (mq.size() > 0);
        acc = t && (f || mq.size() < DEPTH || pop);
        if (pop) begin
            nn = mq.pop_front();
            fq.push_back(8'hA5);
            exp_q.push_back(8'hA5);
            for (int k = 3; k >= 0; k--) begin
                fq.push_back(nn[8*k +: 8]);
                exp_q.push_back(nn[8*k +: 8]);
            end
        end
        if (f) begin
            mq.delete();
            m_drop  = 0;
            m_drop2 = 0;
            m_ovf   = 1'b0;
        end
        if (acc) begin
            mq.push_back(n);
        end else if (t) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
            if (m_drop2 < 3) m_drop2++;
        end
    endtask

    task automatic cyc(input logic t, input logic [31:0] n, input logic f,
                       input logic r, input logic rs);
        new_golden_ticket = t;
        golden_nonce      = n;
        flush             = f;
        tx_ready          = r;
        reset             = rs;
        @(posedge hash_clk);
        model_step(t, n, f, r, rs);
        #1;
    endtask

    // Monitor: sample mid-cycle, consume expected bytes on each handshake.
    always @(negedge hash_clk) begin
        if (mon_en) begin
            check("tx_valid", 32'(tx_valid), 32'(fq.size() > 0));
            check("busy", 32'(busy), 32'(fq.size() > 0));
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("drop_count", 32'(drop_count), 32'(m_drop));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count_sat", 32'(drop_count2), 32'(m_drop2));
            check("overflow_sat", 32'(overflow2), 32'(m_ovf));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                else
                    check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 1);
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 1);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);

        // Single nonce with free-running ready.
        cyc(1, 32'hDEADBEEF, 0, 1, 0);
        check("lat_not_yet", 32'(tx_valid), 0);
        cyc(0, 0, 0, 1, 0);
        check("lat_sof_valid", 32'(tx_valid), 1);
        check("lat_sof_byte", 32'(tx_data), 32'hA5);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        check("single_idle", 32'(busy), 0);

        // Backpressure: ready 1,0,0,1,...
        cyc(1, 32'hDEADBEEF, 0, 1, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, 0, (i % 4 == 0) || (i % 4 == 3), 0);

        // Burst with ready low: 1 framed, 4 queued, 1 dropped.
        for (int n = 1; n <= 6; n++) cyc(1, 32'(n), 0, 0, 0);
        check("burst_count", 32'(fifo_count), 4);
        check("burst_drop", 32'(drop_count), 1);
        check("burst_ovf", 32'(overflow), 1);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1, 0);

        // Flush while B2 of 11223344 is on the wire.
        cyc(1, 32'h11223344, 0, 1, 0);
        cyc(1, 32'h55667788, 0, 1, 0);
        cyc(1, 32'h99AABBCC, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("in_b2", 32'(tx_data), 32'h22);
        cyc(0, 0, 1, 1, 0);
        check("flush_count", 32'(fifo_count), 0);
        check("flush_ovf", 32'(overflow), 0);
        check("flush_busy", 32'(busy), 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);

        // Flush together with a push.
        cyc(1, 32'h00001000, 0, 0, 0);
        cyc(1, 32'h00002000, 0, 0, 0);
        cyc(1, 32'h00003000, 0, 0, 0);
        check("pre_flush_count", 32'(fifo_count), 2);
        cyc(1, 32'hCAFEF00D, 1, 0, 0);
        check("flush_push_count", 32'(fifo_count), 1);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);

        // Saturating counter, then reset in B1.
        for (int n = 0; n < 10; n++) cyc(1, 32'h7000_0000 + 32'(n), 0, 0, 0);
        check("drop5", 32'(drop_count), 5);
        check("drop_sat", 32'(drop_count2), 3);
        check("ovf_sat", 32'(overflow2), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        check("in_b1", 32'(tx_data), 32'h00);
        cyc(0, 0, 0, 1, 1);
        check("mid_rst_valid", 32'(tx_valid), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_drop", 32'(drop_count), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_busy", 32'(busy), 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(99, 0) < 30, $urandom,
                $urandom_range(99, 0) < 3,
                $urandom_range(99, 0) < 60,
                $urandom_range(999, 0) < 5);

        // Drain, bounded.
        for (int i = 0; i < 200 && (exp_q.size() > 0 || mq.size() > 0 || busy); i++)
            cyc(0, 0, 0, 1, 0);
        check("drain_done", 32'(exp_q.size() + mq.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
